uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Host-side controller for the UART receive FIFO (FWFT, exposes rx_ready/rx_data/parity_err, pops on rx_req).
- Sequences single-word host reads and full FIFO flushes.
- Tracks a character-timeout condition by monitoring the raw RX line.
- Produces sticky status flags and one maskable interrupt; sits between the RX FIFO block and the register file.

Parameters:
- WIDTH, 8, data bits per character; must match the FIFO data width.
- TO_WIDTH, 24, width of the timeout counter and cfg_timeout.
- SYNC_STAGES, 2, flop stages in the RX-line synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_ready  in  1  FIFO non-empty
- rx_data  in  WIDTH  FIFO head word (FWFT)
- parity_err  in  1  parity error flag of the head word
- rx_req  out  1  FIFO pop strobe
- uart_rx  in  1  raw serial RX line; activity monitor only
- rd_en  in  1  host read request pulse
- rd_data  out  WIDTH  captured read word
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- rd_busy  out  1  controller not in IDLE; rd_en is ignored
- flush  in  1  drain-FIFO request pulse
- cfg_timeout  in  TO_WIDTH  timeout in clk cycles; 0 disables timeout
- ien  in  3  interrupt enables {perr, timeout, avail}
- sts_clr  in  3  write-1-to-clear for {perr, timeout, underflow}
- sts  out  4  {flushing, perr_sticky, to_flag, underflow_sticky}
- irq  out  1  level interrupt

Behaviour:
- Reset: every register cleared. Outputs rd_data=0, rd_valid=0, rx_req=0, sts=0, irq=0. State is IDLE.
- States are IDLE, POP, SETTLE, FLUSH. rd_busy = (state != IDLE).
- Read, IDLE with rd_en=1 and rx_ready=1 at edge N:
  - rd_data <= rx_data; rd_valid=1 during N+1.
  - If parity_err=1, perr_sticky <= 1.
  - State goes to POP: rx_req=1 (registered) during N+1.
  - State goes to SETTLE during N+2, then IDLE.
  - Minimum spacing between accepted reads is 3 cycles.
- Read, IDLE with rd_en=1 and rx_ready=0:
  - rd_data <= 0, rd_valid pulses, underflow_sticky <= 1.
  - No pop is issued; state stays IDLE.
- rd_en while rd_busy=1: ignored, with no side effects.
- Flush:
  - A flush pulse in any state sets flush_pend. When state==IDLE and flush_pend=1, move to FLUSH and clear flush_pend.
  - flush has priority over a same-cycle rd_en.
  - In FLUSH, rx_req = rx_ready (combinational); rd_data is unchanged and perr_sticky is not updated.
  - Exit to IDLE after 2 consecutive cycles with rx_ready=0; this covers the FIFO empty-flag latency.
  - Entering FLUSH clears to_flag. sts[3] = (state==FLUSH) | flush_pend.
- RX line monitor:
  - uart_rx passes through SYNC_STAGES flops, reset value 1 (idle line).
  - line_fall = sync_prev & ~sync_cur.
- Timeout counter to_cnt (TO_WIDTH bits):
  - Cleared when rx_ready=0, when rx_req=1, on line_fall, or when state!=IDLE.
  - Otherwise increments, saturating at all-ones.
  - When cfg_timeout!=0 and to_cnt == cfg_timeout-1 while incrementing, to_flag <= 1.
  - to_flag is sticky. It clears on sts_clr[1], any pop, or FLUSH entry.
  - A cfg_timeout change mid-count takes effect on the next comparison; no restart.
- Sticky flags: when a set and a clear hit the same flag in the same cycle, set wins.
- irq is a registered OR of three terms:
  - ien[0] & rx_ready
  - ien[1] & to_flag
  - ien[2] & perr_sticky
- A FIFO flush does not clear perr_sticky or underflow_sticky.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE=2'd0, POP=2'd1, SETTLE=2'd2, FLUSH=2'd3;
  - STS_* and IEN_* bit indices;
  - the flush exit count constant (2).
- One sub-module, uart_line_sync:
  - SYNC_STAGES synchronizer with reset-to-1;
  - falling-edge pulse output.
- Reused by the TX side for CTS monitoring.

Test Plan:
- Read with data: push 0xA5 into the FIFO, pulse rd_en. Expect rd_data=0xA5, a 1-cycle rd_valid pulse, a 1-cycle rx_req pulse the cycle after acceptance, rx_ready dropping, and rd_busy high for 2 cycles.
- Underflow: FIFO empty, pulse rd_en. Expect rd_valid with rd_data=0x00, underflow_sticky=1, and no rx_req. Then pulse sts_clr[0] in the same cycle as another underflow read; the flag must remain 1.
- Flush:
  - Fill the FIFO with 8 words, pulse flush. Expect rx_req held for 8 cycles, FIFO empty, IDLE reached 2 cycles after rx_ready falls, and sts[3] high throughout.
  - Repeat with flush pulsed during SETTLE; the flush must still execute.
- Timeout: cfg_timeout=100, one word in the FIFO, line idle. Expect to_flag=1 exactly 100 cycles after rx_ready rises, and irq=1 with ien[1]=1.
  - Repeat with a uart_rx falling edge at cycle 60; to_flag must rise 100 cycles after the synchronized edge.
  - With cfg_timeout=0, to_flag never sets.
- Parity: word 0x3C pushed with parity_err=1, ien=3'b100, then read. Expect perr_sticky=1 and irq=1 on the next cycle. After sts_clr[2], perr_sticky=0 and irq=0.
- Async reset mid-FLUSH with 4 words remaining: all outputs are immediately 0 and the state is IDLE. After release, FIFO contents are untouched by the controller.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : uart_pkg                                                   |
// | Shared definitions for the UART RX host-side controller:            |
// |   - FSM state encoding                                               |
// |   - bit positions inside sts / sts_clr / ien                         |
// |   - number of consecutive empty cycles that ends a flush             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  // sts bit positions; sts_clr uses the same positions for bits 2..0
  localparam int STS_UFLOW = 0;
  localparam int STS_TO    = 1;
  localparam int STS_PERR  = 2;
  localparam int STS_FLUSH = 3;

  // ien bit positions
  localparam int IEN_AVAIL = 0;
  localparam int IEN_TO    = 1;
  localparam int IEN_PERR  = 2;

  // The FIFO empty flag lags a pop by a cycle, so one low sample of
  // rx_ready is not proof the FIFO has drained.
  localparam int c_FLUSH_EXIT_CNT = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : uart_rx_ctrl_if                                          |
// | Groups the RX FIFO read port (FWFT) and the host read/flush port.    |
// |   slave  : the controller (consumes FIFO head, serves host)          |
// |   master : the environment (FIFO + register file side)              |
// | Signals: rx_ready, rx_data, parity_err, rx_req (FIFO side)           |
// |          rd_en, rd_data, rd_valid, rd_busy, flush (host side)        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface uart_rx_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             rx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             parity_err;
  logic             rx_req;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_busy;
  logic             flush;

  modport slave (
    input  rx_ready, rx_data, parity_err, rd_en, flush,
    output rx_req, rd_data, rd_valid, rd_busy
  );

  modport master (
    output rx_ready, rx_data, parity_err, rd_en, flush,
    input  rx_req, rd_data, rd_valid, rd_busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_line_sync                                             |
// | Multi-flop synchronizer for an asynchronous serial line plus a       |
// | one-cycle falling-edge pulse. Flops reset to 1 (idle line level) so  |
// | reset release never fakes a start-bit edge.                          |
// | Ports: clk, rst, i_line (raw line), o_fall (falling-edge pulse)      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rx_ctrl                                               |
// | Host-side controller for the UART RX FIFO: single-word reads, full   |
// | FIFO flushes, character timeout detection, sticky status, irq.      |
// | Ports: clk, rst (async, active-high)                                 |
// |        bus         : FIFO read port + host read/flush (slave side)   |
// |        uart_rx     : raw RX line, activity monitor only              |
// |        cfg_timeout : timeout in clk cycles, 0 disables               |
// |        ien         : {perr, timeout, avail} interrupt enables        |
// |        sts_clr     : W1C {perr, timeout, underflow}                  |
// |        sts         : {flushing, perr, timeout, underflow}            |
// |        irq         : registered level interrupt                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TO_WIDTH    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  uart_rx_ctrl_if.slave       bus,
  input  logic                uart_rx,
  input  logic [TO_WIDTH-1:0] cfg_timeout,
  input  logic [2:0]          ien,
  input  logic [2:0]          sts_clr,
  output logic [3:0]          sts,
  output logic                irq
);

  localparam logic [1:0] c_EXIT_LAST = 2'(c_FLUSH_EXIT_CNT - 1);

  state_t              r_state;
  logic                r_flush_pend;
  logic                r_pop;
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_rd_valid;
  logic [1:0]          r_empty_cnt;
  logic                r_perr;
  logic                r_uflow;
  logic                r_to_flag;
  logic [TO_WIDTH-1:0] r_to_cnt;
  logic                r_irq;

  logic w_line_fall;
  logic w_rx_req;
  logic w_flush_entry;
  logic w_to_clear;
  logic w_to_hit;

  uart_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk    (clk),
    .rst    (rst),
    .i_line (uart_rx),
    .o_fall (w_line_fall)
  );

  // Pop is a registered strobe for reads; during a flush it follows the
  // FIFO's non-empty flag directly so a full drain takes one cycle/word.
  assign w_rx_req      = r_pop | ((r_state == FLUSH) & bus.rx_ready);
  assign w_flush_entry = (r_state == IDLE) & r_flush_pend;

  // The counter only runs while a word sits unread with a quiet line.
  assign w_to_clear = ~bus.rx_ready | w_rx_req | w_line_fall | (r_state != IDLE);
  assign w_to_hit   = ~w_to_clear & (cfg_timeout != '0)
                    & (r_to_cnt == cfg_timeout - TO_WIDTH'(1));

  // Control FSM, read path and read-related sticky flags. Clears are
  // written first so a same-cycle set overrides them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_flush_pend <= 1'b0;
      r_pop        <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_empty_cnt  <= '0;
      r_perr       <= 1'b0;
      r_uflow      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_pop      <= 1'b0;
      if (sts_clr[STS_PERR])  r_perr  <= 1'b0;
      if (sts_clr[STS_UFLOW]) r_uflow <= 1'b0;
      if (bus.flush)          r_flush_pend <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_flush_pend) begin
            // A flush pulse landing on the entry cycle is absorbed by
            // the flush that is starting now.
            r_state      <= FLUSH;
            r_flush_pend <= 1'b0;
            r_empty_cnt  <= '0;
          end else if (bus.rd_en && !bus.flush) begin
            r_rd_valid <= 1'b1;
            if (bus.rx_ready) begin
              r_rd_data <= bus.rx_data;
              r_pop     <= 1'b1;
              r_state   <= POP;
              if (bus.parity_err) r_perr <= 1'b1;
            end else begin
              r_rd_data <= '0;
              r_uflow   <= 1'b1;
            end
          end
        end
        POP:    r_state <= SETTLE;
        // SETTLE gives the FIFO a cycle to update its head after the pop.
        SETTLE: r_state <= IDLE;
        FLUSH: begin
          if (bus.rx_ready) begin
            r_empty_cnt <= '0;
          end else if (r_empty_cnt == c_EXIT_LAST) begin
            r_empty_cnt <= '0;
            r_state     <= IDLE;
          end else begin
            r_empty_cnt <= r_empty_cnt + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Character timeout and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_to_clear)       r_to_cnt <= '0;
      else if (~&r_to_cnt)  r_to_cnt <= r_to_cnt + TO_WIDTH'(1);

      if (w_to_hit)
        r_to_flag <= 1'b1;
      else if (sts_clr[STS_TO] | w_rx_req | w_flush_entry)
        r_to_flag <= 1'b0;

      r_irq <= (ien[IEN_AVAIL] & bus.rx_ready)
             | (ien[IEN_TO]    & r_to_flag)
             | (ien[IEN_PERR]  & r_perr);
    end
  end

  assign bus.rx_req   = w_rx_req;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_busy  = (r_state != IDLE);
  assign irq          = r_irq;

  always_comb begin
    sts            = '0;
    sts[STS_FLUSH] = (r_state == FLUSH) | r_flush_pend;
    sts[STS_PERR]  = r_perr;
    sts[STS_TO]    = r_to_flag;
    sts[STS_UFLOW] = r_uflow;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_rx_ctrl                                            |
// | Self-checking bench for uart_rx_ctrl with a behavioural FWFT FIFO   |
// | and a queue of expected words. Timing expectations are computed     |
// | arithmetically from the controller's documented behaviour.          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_uart_rx_ctrl;

  localparam int WIDTH       = 8;
  localparam int TO_WIDTH    = 24;
  localparam int SYNC_STAGES = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                uart_rx;
  logic [TO_WIDTH-1:0] cfg_timeout;
  logic [2:0]          ien;
  logic [2:0]          sts_clr;
  logic [3:0]          sts;
  logic                irq;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_ctrl_if #(.WIDTH(WIDTH)) bus ();

  uart_rx_ctrl #(
    .WIDTH       (WIDTH),
    .TO_WIDTH    (TO_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .uart_rx     (uart_rx),
    .cfg_timeout (cfg_timeout),
    .ien         (ien),
    .sts_clr     (sts_clr),
    .sts         (sts),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Behavioural FWFT FIFO: {parity_err, data} words, unbounded counters.
  logic [WIDTH:0] mem [0:31];
  int             wr_cnt = 0;
  int             rd_cnt = 0;
  logic           push_v;
  logic [WIDTH:0] push_w;
  logic [WIDTH-1:0] exp_q [$];

  assign bus.rx_ready   = (wr_cnt != rd_cnt);
  assign bus.rx_data    = mem[rd_cnt[4:0]][WIDTH-1:0];
  assign bus.parity_err = mem[rd_cnt[4:0]][WIDTH];

  always @(posedge clk) begin
    if (push_v) begin
      mem[wr_cnt[4:0]] <= push_w;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.rx_req === 1'b1 && wr_cnt != rd_cnt) rd_cnt <= rd_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d, input logic p);
    push_v = 1'b1;
    push_w = {p, d};
    exp_q.push_back(d);
    tick();
    push_v = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.rd_data !== '0 || bus.rd_valid !== 1'b0 || bus.rx_req !== 1'b0 || bus.rd_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: rd_data=%h rd_valid=%b rx_req=%b rd_busy=%b, want 0/0/0/0",
               bus.rd_data, bus.rd_valid, bus.rx_req, bus.rd_busy);
    end
    n_checks++;
    if (sts !== 4'b0 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_status: sts=%b irq=%b, want 0000/0", sts, irq);
    end
  endtask

  task automatic test_read();
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      do_push(d, 1'b0);
      e = exp_q.pop_front();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      n_checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e || bus.rx_req !== 1'b1 || bus.rd_busy !== 1'b1) begin
        n_errors++;
        $display("FAIL read_accept: valid=%b data=%h req=%b busy=%b, want 1/%h/1/1",
                 bus.rd_valid, bus.rd_data, bus.rx_req, bus.rd_busy, e);
      end
      tick();
      n_checks++;
      if (bus.rd_valid !== 1'b0 || bus.rx_req !== 1'b0 || bus.rd_busy !== 1'b1 || bus.rx_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL read_settle: valid=%b req=%b busy=%b rx_ready=%b, want 0/0/1/0",
                 bus.rd_valid, bus.rx_req, bus.rd_busy, bus.rx_ready);
      end
      tick();
      n_checks++;
      if (bus.rd_busy !== 1'b0 || bus.rd_data !== e) begin
        n_errors++;
        $display("FAIL read_done: busy=%b data=%h, want 0/%h", bus.rd_busy, bus.rd_data, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    int last_v = -10;
    int bad_gap = 0;
    int bad_data = 0;
    logic [WIDTH-1:0] e;
    for (int i = 0; i < 4; i++) do_push(8'($urandom), 1'b0);
    bus.rd_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.rd_valid === 1'b1) begin
        nvalid++;
        if (k - last_v != 3 && last_v >= 0) bad_gap++;
        last_v = k;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        if (bus.rd_data !== e) bad_data++;
      end
    end
    bus.rd_en = 1'b0;
    tick();
    n_checks++;
    if (nvalid != 4 || bad_gap != 0 || bad_data != 0) begin
      n_errors++;
      $display("FAIL b2b_reads: valid=%0d gaps_bad=%0d data_bad=%0d, want 4/0/0", nvalid, bad_gap, bad_data);
    end
    n_checks++;
    if (sts[0] !== 1'b0 || bus.rx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_no_underflow: uflow=%b rx_ready=%b, want 0/0", sts[0], bus.rx_ready);
    end
  endtask

  task automatic test_underflow();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h00 || bus.rx_req !== 1'b0 || bus.rd_busy !== 1'b0 || sts[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow: valid=%b data=%h req=%b busy=%b uflow=%b, want 1/00/0/0/1",
               bus.rd_valid, bus.rd_data, bus.rx_req, bus.rd_busy, sts[0]);
    end
    bus.rd_en = 1'b1;
    sts_clr   = 3'b001;
    tick();
    bus.rd_en = 1'b0;
    sts_clr   = 3'b000;
    n_checks++;
    if (sts[0] !== 1'b1 || bus.rd_valid !== 1'b1 || bus.rx_req !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_set_wins: uflow=%b valid=%b req=%b, want 1/1/0", sts[0], bus.rd_valid, bus.rx_req);
    end
    sts_clr = 3'b001;
    tick();
    sts_clr = 3'b000;
    n_checks++;
    if (sts[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_clear: uflow=%b, want 0", sts[0]);
    end
  endtask

  task automatic test_flush(input bit in_settle, input int n);
    int fl_cyc = 1;
    int req_cyc = 0;
    int fall_at = -1;
    int idle_at = -1;
    int k = 0;
    logic [WIDTH-1:0] rd_before;
    if (!in_settle) begin
      for (int i = 0; i < n; i++) do_push(8'($urandom), 1'b0);
      rd_before = bus.rd_data;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
    end else begin
      for (int i = 0; i <= n; i++) do_push(8'($urandom), 1'b0);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      rd_before = exp_q.pop_front();
      n_checks++;
      if (bus.rd_data !== rd_before) begin
        n_errors++;
        $display("FAIL flush_pre_read: data=%h, want %h", bus.rd_data, rd_before);
      end
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
    end
    n_checks++;
    if (sts[3] !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_pending: sts3=%b, want 1", sts[3]);
    end
    while (sts[3] === 1'b1 && k < 60) begin
      tick();
      k++;
      if (bus.rx_req === 1'b1) req_cyc++;
      if (fall_at < 0 && bus.rx_ready === 1'b0) fall_at = k;
      if (idle_at < 0 && bus.rd_busy === 1'b0) idle_at = k;
      if (sts[3] === 1'b1) fl_cyc++;
    end
    exp_q.delete();
    n_checks++;
    if (k >= 60 || req_cyc != n || fl_cyc != n + 3) begin
      n_errors++;
      $display("FAIL flush_counts: cycles=%0d req=%0d flushing=%0d, want <60/%0d/%0d", k, req_cyc, fl_cyc, n, n + 3);
    end
    n_checks++;
    if (idle_at - fall_at != 2 || wr_cnt != rd_cnt) begin
      n_errors++;
      $display("FAIL flush_exit: idle-fall=%0d fifo_level=%0d, want 2/0", idle_at - fall_at, wr_cnt - rd_cnt);
    end
    n_checks++;
    if (bus.rd_data !== rd_before) begin
      n_errors++;
      $display("FAIL flush_rd_data: data=%h, want %h", bus.rd_data, rd_before);
    end
  endtask

  // Expected flag cycle: cfg cycles after the later of the word arrival
  // and the counter clear caused by a synchronized falling edge.
  task automatic test_timeout(input int cfg, input int drop_at, input bit use_flush);
    int exp_flag;
    int limit;
    int first_flag = -1;
    int first_irq = -1;
    cfg_timeout = TO_WIDTH'(cfg);
    ien = 3'b010;
    sts_clr = 3'b111;
    tick();
    sts_clr = 3'b000;
    exp_flag = (cfg == 0) ? -1 : (drop_at >= 0 ? cfg + drop_at + SYNC_STAGES + 1 : cfg);
    limit = (cfg == 0) ? 300 : exp_flag + 3;
    do_push(8'($urandom), 1'b0);
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (first_flag < 0 && sts[1] === 1'b1) first_flag = k;
      if (first_irq < 0 && irq === 1'b1) first_irq = k;
      if (k == drop_at) uart_rx = 1'b0;
      if (k == drop_at + 5) uart_rx = 1'b1;
    end
    n_checks++;
    if (first_flag != exp_flag) begin
      n_errors++;
      $display("FAIL timeout_flag cfg=%0d drop=%0d: first at %0d, want %0d", cfg, drop_at, first_flag, exp_flag);
    end
    n_checks++;
    if (first_irq != ((cfg == 0) ? -1 : exp_flag + 1)) begin
      n_errors++;
      $display("FAIL timeout_irq cfg=%0d: first at %0d, want %0d", cfg, first_irq, (cfg == 0) ? -1 : exp_flag + 1);
    end
    if (use_flush) begin
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      n_checks++;
      if (sts[1] !== 1'b0 || bus.rd_busy !== 1'b1) begin
        n_errors++;
        $display("FAIL timeout_flush_clear: to_flag=%b busy=%b, want 0/1", sts[1], bus.rd_busy);
      end
      for (int k = 0; k < 20 && sts[3] === 1'b1; k++) tick();
      exp_q.delete();
    end else begin
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      void'(exp_q.pop_front());
      tick();
      tick();
      n_checks++;
      if (sts[1] !== 1'b0 || bus.rx_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL timeout_pop_clear: to_flag=%b rx_ready=%b, want 0/0", sts[1], bus.rx_ready);
      end
    end
    cfg_timeout = '0;
  endtask

  task automatic test_parity();
    ien = 3'b100;
    sts_clr = 3'b111;
    tick();
    sts_clr = 3'b000;
    do_push(8'h3C, 1'b1);
    void'(exp_q.pop_front());
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.rd_data !== 8'h3C || sts[2] !== 1'b1 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL parity_read: data=%h perr=%b irq=%b, want 3c/1/0", bus.rd_data, sts[2], irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++;
      $display("FAIL parity_irq: irq=%b, want 1", irq);
    end
    tick();
    do_push(8'($urandom), 1'b0);
    do_push(8'($urandom), 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int k = 0; k < 20 && sts[3] === 1'b1; k++) tick();
    exp_q.delete();
    n_checks++;
    if (sts[2] !== 1'b1 || wr_cnt != rd_cnt) begin
      n_errors++;
      $display("FAIL parity_survives_flush: perr=%b level=%0d, want 1/0", sts[2], wr_cnt - rd_cnt);
    end
    sts_clr = 3'b100;
    tick();
    sts_clr = 3'b000;
    n_checks++;
    if (sts[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL parity_clear: perr=%b, want 0", sts[2]);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++;
      $display("FAIL parity_irq_clear: irq=%b, want 0", irq);
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    ien = 3'b001;
    for (int i = 0; i < 8; i++) do_push(8'($urandom), 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    while ((wr_cnt - rd_cnt) != 4 && k < 30) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= 30 || bus.rx_req !== 1'b1 || irq !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_precond: wait=%0d req=%b irq=%b, want <30/1/1", k, bus.rx_req, irq);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.rx_req !== 1'b0 || bus.rd_busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || sts !== 4'b0 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL areset_immediate: req=%b busy=%b valid=%b data=%h sts=%b irq=%b, want all 0",
               bus.rx_req, bus.rd_busy, bus.rd_valid, bus.rd_data, sts, irq);
    end
    tick();
    tick();
    rst = 1'b0;
    ien = 3'b000;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if ((wr_cnt - rd_cnt) != 4 || bus.rd_busy !== 1'b0 || bus.rx_req !== 1'b0) begin
      n_errors++;
      $display("FAIL areset_fifo_kept: level=%0d busy=%b req=%b, want 4/0/0", wr_cnt - rd_cnt, bus.rd_busy, bus.rx_req);
    end
  endtask

  initial begin
    rst         = 1'b1;
    uart_rx     = 1'b1;
    cfg_timeout = '0;
    ien         = 3'b000;
    sts_clr     = 3'b000;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    push_v      = 1'b0;
    push_w      = '0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_read();
    test_back_to_back();
    test_underflow();
    test_flush(1'b0, 8);
    test_flush(1'b0, int'($urandom_range(3, 12)));
    test_flush(1'b1, 5);
    test_timeout(100, -1, 1'b1);
    test_timeout(100, 60, 1'b0);
    test_timeout(0, -1, 1'b0);
    for (int i = 0; i < 3; i++) test_timeout(int'($urandom_range(5, 40)), -1, 1'b0);
    test_parity();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
